// File: rtl/spc_pcx_req_ctl.sv
// spc_pcx_req_ctl
//   Core-side PCX request issue and credit controller. Accepts one-hot
//   destination requests from the core PCX queue, drives single-cycle request
//   strobes toward the PCX, keeps per-destination outstanding counters that
//   are returned on grant, and holds off new requests while the PCX stalls.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for a new request (subject to stall and credit)
//   BEAT2  | first beat of an atomic pair issued; second beat goes out now
//
// Ports
//   rclk                    core clock, rising edge
//   reset                   synchronous active-high reset
//   req_vld                 core has a request this cycle
//   req_dest[4:0]           one-hot destination (3:0 L2 banks, 4 FPU/IO)
//   req_atom                request is an atomic two-packet pair
//   pcx_spc_grant_bufpm_pa  per-destination grant, one pulse per packet
//   pcx_stall_bufpm_pq      PCX stall, blocks new accepts
//   req_rdy                 combinational accept qualifier
//   spc_pcx_req_pq          registered one-hot request strobe
//   spc_pcx_atom_pq         registered, first beat of an atomic pair
//   pcx_idle                registered, nothing outstanding
//   pcx_cred_err            registered, sticky spurious-grant flag
module spc_pcx_req_ctl #(
    parameter int DEPTH = 2   // 2 or 3; counters are 2 bits wide
) (
    input  logic       rclk,
    input  logic       reset,
    input  logic       req_vld,
    input  logic [4:0] req_dest,
    input  logic       req_atom,
    input  logic [4:0] pcx_spc_grant_bufpm_pa,
    input  logic       pcx_stall_bufpm_pq,
    output logic       req_rdy,
    output logic [4:0] spc_pcx_req_pq,
    output logic       spc_pcx_atom_pq,
    output logic       pcx_idle,
    output logic       pcx_cred_err
);

    localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
    localparam logic [1:0] DEPTH_M2 = 2'(DEPTH - 2);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] beat2_dest;
    logic [1:0] outst [5];

    logic       beat2;
    logic       dest_onehot;
    logic [1:0] sel_cnt;
    logic       credit_ok;
    logic       accept;
    logic [1:0] cnt_nxt [5];
    logic [4:0] spurious;
    logic       idle_nxt;

    assign beat2 = (state == ST_BEAT2);

    assign dest_onehot = (req_dest != 5'd0) &&
                         ((req_dest & (req_dest - 5'd1)) == 5'd0);

    // Counter of the selected destination; valid only when req_dest is one-hot.
    always_comb begin
        sel_cnt = 2'd0;
        for (int d = 0; d < 5; d++) begin
            if (req_dest[d]) sel_cnt = sel_cnt | outst[d];
        end
    end

    // An atomic pair needs two free slots up front so the second beat never
    // has to wait for credit.
    assign credit_ok = dest_onehot &&
                       (req_atom ? (sel_cnt <= DEPTH_M2) : (sel_cnt < DEPTH_C));

    assign req_rdy = !reset && !pcx_stall_bufpm_pq && !beat2 && credit_ok;
    assign accept  = req_vld && req_rdy;

    // A grant against an empty counter is discarded and flagged; otherwise
    // accept and grant to the same destination combine into a net update.
    // Sum never exceeds DEPTH because req_rdy guards the increment.
    always_comb begin
        spurious = 5'd0;
        for (int d = 0; d < 5; d++) begin
            logic [1:0] inc;
            logic [1:0] dec;
            inc = 2'd0;
            dec = 2'd0;
            if (accept && req_dest[d]) inc = req_atom ? 2'd2 : 2'd1;
            if (pcx_spc_grant_bufpm_pa[d]) begin
                if (outst[d] == 2'd0) spurious[d] = 1'b1;
                else                  dec = 2'd1;
            end
            cnt_nxt[d] = outst[d] + inc - dec;
        end
    end

    always_comb begin
        idle_nxt = !(accept && req_atom);
        for (int d = 0; d < 5; d++) begin
            if (cnt_nxt[d] != 2'd0) idle_nxt = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state           <= ST_IDLE;
            beat2_dest      <= 5'd0;
            spc_pcx_req_pq  <= 5'd0;
            spc_pcx_atom_pq <= 1'b0;
            pcx_idle        <= 1'b1;
            pcx_cred_err    <= 1'b0;
            for (int d = 0; d < 5; d++) outst[d] <= 2'd0;
        end else begin
            for (int d = 0; d < 5; d++) outst[d] <= cnt_nxt[d];
            pcx_idle     <= idle_nxt;
            pcx_cred_err <= pcx_cred_err | (|spurious);

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        spc_pcx_req_pq  <= req_dest;
                        spc_pcx_atom_pq <= req_atom;
                        if (req_atom) begin
                            state      <= ST_BEAT2;
                            beat2_dest <= req_dest;
                        end
                    end else begin
                        spc_pcx_req_pq  <= 5'd0;
                        spc_pcx_atom_pq <= 1'b0;
                    end
                end
                ST_BEAT2: begin
                    // Second beat goes out regardless of stall to keep the pair contiguous.
                    spc_pcx_req_pq  <= beat2_dest;
                    spc_pcx_atom_pq <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    spc_pcx_req_pq  <= 5'd0;
                    spc_pcx_atom_pq <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spc_pcx_req_ctl.sv
module tb_spc_pcx_req_ctl;

    logic       rclk = 1'b0;
    logic       reset;
    logic       req_vld;
    logic [4:0] req_dest;
    logic       req_atom;
    logic [4:0] grant;
    logic       stall;
    logic       req_rdy;
    logic [4:0] req_pq;
    logic       atom_pq;
    logic       pcx_idle;
    logic       cred_err;

    int n_checks = 0;
    int n_fail   = 0;

    spc_pcx_req_ctl #(.DEPTH(2)) dut (
        .rclk                   (rclk),
        .reset                  (reset),
        .req_vld                (req_vld),
        .req_dest               (req_dest),
        .req_atom               (req_atom),
        .pcx_spc_grant_bufpm_pa (grant),
        .pcx_stall_bufpm_pq     (stall),
        .req_rdy                (req_rdy),
        .spc_pcx_req_pq         (req_pq),
        .spc_pcx_atom_pq        (atom_pq),
        .pcx_idle               (pcx_idle),
        .pcx_cred_err           (cred_err)
    );

    always #5 rclk = ~rclk;

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_vld = 1'b0; req_dest = 5'd0; req_atom = 1'b0;
        grant = 5'd0; stall = 1'b0;
        cyc(); cyc();

        // Reset state; req_rdy held low while reset is high
        req_vld = 1'b1; req_dest = 5'b00001; #1;
        chk("rst_rdy", 32'(req_rdy), 0);
        chk("rst_req", 32'(req_pq), 0);
        chk("rst_atom", 32'(atom_pq), 0);
        chk("rst_idle", 32'(pcx_idle), 1);
        chk("rst_err", 32'(cred_err), 0);
        req_vld = 1'b0;
        reset = 1'b0;
        cyc();

        // Single request to bank 0, then drain
        req_vld = 1'b1; req_dest = 5'b00001; req_atom = 1'b0; #1;
        chk("t1_rdy", 32'(req_rdy), 1);
        cyc();
        req_vld = 1'b0;
        chk("t1_req", 32'(req_pq), 32'b00001);
        chk("t1_atom", 32'(atom_pq), 0);
        chk("t1_idle", 32'(pcx_idle), 0);
        chk("t1_outst0", 32'(dut.outst[0]), 1);
        cyc();
        chk("t1_req_off", 32'(req_pq), 0);
        grant = 5'b00001;
        cyc();
        grant = 5'd0;
        chk("t1_idle_back", 32'(pcx_idle), 1);
        chk("t1_outst0_0", 32'(dut.outst[0]), 0);

        // Credit exhaustion on bank 2
        req_vld = 1'b1; req_dest = 5'b00100; #1;
        chk("t2_rdy1", 32'(req_rdy), 1);
        cyc();
        chk("t2_rdy2", 32'(req_rdy), 1);
        chk("t2_req1", 32'(req_pq), 32'b00100);
        cyc();
        chk("t2_rdy3", 32'(req_rdy), 0);
        chk("t2_req2", 32'(req_pq), 32'b00100);
        cyc();
        chk("t2_req_none", 32'(req_pq), 0);
        chk("t2_rdy3b", 32'(req_rdy), 0);
        grant = 5'b00100; #1;
        chk("t2_rdy_grant_cyc", 32'(req_rdy), 0);
        cyc();
        grant = 5'd0; #1;
        chk("t2_rdy_after_grant", 32'(req_rdy), 1);
        cyc();
        req_vld = 1'b0;
        chk("t2_req3", 32'(req_pq), 32'b00100);
        chk("t2_outst2", 32'(dut.outst[2]), 2);
        grant = 5'b00100; cyc();
        grant = 5'b00100; cyc();
        grant = 5'd0;
        chk("t2_idle", 32'(pcx_idle), 1);

        // Atomic to FPU/IO
        req_vld = 1'b1; req_dest = 5'b10000; req_atom = 1'b1; #1;
        chk("t3_rdy", 32'(req_rdy), 1);
        cyc();
        chk("t3_beat1", 32'(req_pq), 32'b10000);
        chk("t3_atom1", 32'(atom_pq), 1);
        chk("t3_rdy_beat2", 32'(req_rdy), 0);
        chk("t3_idle", 32'(pcx_idle), 0);
        cyc();
        chk("t3_beat2", 32'(req_pq), 32'b10000);
        chk("t3_atom2", 32'(atom_pq), 0);
        chk("t3_outst4", 32'(dut.outst[4]), 2);
        chk("t3_rdy_full", 32'(req_rdy), 0);
        cyc();
        chk("t3_req_off", 32'(req_pq), 0);
        grant = 5'b10000;
        cyc();
        grant = 5'd0; #1;
        chk("t3_rdy_one_free", 32'(req_rdy), 0);
        grant = 5'b10000;
        cyc();
        grant = 5'd0; #1;
        chk("t3_rdy_two_free", 32'(req_rdy), 1);
        req_vld = 1'b0; req_atom = 1'b0;
        cyc();
        chk("t3_no_strobe", 32'(req_pq), 0);
        chk("t3_idle_back", 32'(pcx_idle), 1);

        // Stall blocks accept
        stall = 1'b1; req_vld = 1'b1; req_dest = 5'b00010; #1;
        chk("t4_rdy_stall", 32'(req_rdy), 0);
        cyc();
        chk("t4_no_strobe", 32'(req_pq), 0);
        chk("t4_outst1", 32'(dut.outst[1]), 0);

        // Stall rising after atomic accept still lets the second beat out
        stall = 1'b0; req_atom = 1'b1; #1;
        chk("t4_rdy_atom", 32'(req_rdy), 1);
        cyc();
        stall = 1'b1; req_vld = 1'b0; req_atom = 1'b0;
        chk("t4_beat1", 32'(req_pq), 32'b00010);
        chk("t4_atom1", 32'(atom_pq), 1);
        cyc();
        chk("t4_beat2", 32'(req_pq), 32'b00010);
        chk("t4_atom2", 32'(atom_pq), 0);
        stall = 1'b0;
        chk("t4_outst1_2", 32'(dut.outst[1]), 2);

        // Simultaneous accept and grant on bank 1
        grant = 5'b00010;
        cyc();
        chk("t5_outst1_1", 32'(dut.outst[1]), 1);
        req_vld = 1'b1; req_dest = 5'b00010; #1;
        chk("t5_rdy", 32'(req_rdy), 1);
        cyc();
        grant = 5'd0;
        chk("t5_req", 32'(req_pq), 32'b00010);
        chk("t5_outst1_net0", 32'(dut.outst[1]), 1);
        req_dest = 5'b00001; cyc();
        req_dest = 5'b00100; cyc();
        req_dest = 5'b01000; cyc();
        req_vld = 1'b0;
        chk("t5_outst3", 32'(dut.outst[3]), 1);
        grant = 5'b01111;
        cyc();
        grant = 5'd0;
        chk("t5_o0", 32'(dut.outst[0]), 0);
        chk("t5_o1", 32'(dut.outst[1]), 0);
        chk("t5_o2", 32'(dut.outst[2]), 0);
        chk("t5_o3", 32'(dut.outst[3]), 0);
        chk("t5_idle", 32'(pcx_idle), 1);
        chk("t5_err", 32'(cred_err), 0);

        // Spurious grant, sticky error
        grant = 5'b01000;
        cyc();
        grant = 5'd0;
        chk("t6_err", 32'(cred_err), 1);
        chk("t6_outst3", 32'(dut.outst[3]), 0);
        cyc();
        chk("t6_err_sticky", 32'(cred_err), 1);
        reset = 1'b1;
        cyc();
        chk("t6_err_clr", 32'(cred_err), 0);
        reset = 1'b0;

        // Reset mid-atomic aborts the second beat
        req_vld = 1'b1; req_dest = 5'b00001; req_atom = 1'b1; #1;
        chk("t7_rdy", 32'(req_rdy), 1);
        cyc();
        req_vld = 1'b0; req_atom = 1'b0; reset = 1'b1;
        chk("t7_beat1", 32'(req_pq), 32'b00001);
        chk("t7_atom1", 32'(atom_pq), 1);
        cyc();
        chk("t7_abort", 32'(req_pq), 0);
        chk("t7_idle", 32'(pcx_idle), 1);
        chk("t7_outst0", 32'(dut.outst[0]), 0);
        reset = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
